// File: rtl/nop_link_arbiter.sv
// nop_link_arbiter: round-robin flit arbiter that locks the link to one requester per packet.
// Define NOP_LINK_ARB_OUTREG_EN to register the output through a 2-entry skid buffer.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module nop_link_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                         CDCLK,
  input  logic                         CDRESETn,
  input  logic [N_REQ*`DATA_WIDTH-1:0] REQDATA,
  input  logic [N_REQ-1:0]             REQVALID,
  output logic [N_REQ-1:0]             REQREADY,
  output logic [`DATA_WIDTH-1:0]       OUTDATA,
  output logic                         OUTVALID,
  input  logic                         OUTREADY,
  output logic [N_REQ-1:0]             GRANT,
  output logic                         BUSY
);
  localparam int unsigned DW = `DATA_WIDTH;
  localparam int unsigned PW = $clog2(N_REQ);
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic          stall_q, stall_d;
  logic [PW-1:0] stall_idx_q, stall_idx_d;

  logic          found;
  logic [PW-1:0] pick, cand;
  logic          sel_en;
  logic [PW-1:0] sel_idx;
  logic [DW-1:0] sel_data, arb_data;
  logic [1:0]    ftype;
  logic          arb_valid, can_accept, xfer;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (32'(v) == N_REQ - 1) ? '0 : v + PW'(1);
  endfunction

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = ptr_q;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && REQVALID[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // An IDLE grant that stalled is pinned so GRANT/OUTDATA cannot move to a newly valid requester.
  always_comb begin
    sel_en  = 1'b0;
    sel_idx = '0;
    if (CDRESETn) begin
      if (state_q == LOCKED) begin
        sel_en  = 1'b1;
        sel_idx = owner_q;
      end else if (stall_q) begin
        sel_en  = 1'b1;
        sel_idx = stall_idx_q;
      end else if (found) begin
        sel_en  = 1'b1;
        sel_idx = pick;
      end
    end
    sel_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (32'(sel_idx) == k) sel_data = REQDATA[k*DW +: DW];
    end
    arb_valid = sel_en & REQVALID[sel_idx];
    ftype     = sel_data[DW-1:DW-2];
    arb_data  = sel_data;
    if (state_q == IDLE && (ftype == FT_BODY || ftype == FT_TAIL))
      arb_data[DW-1:DW-2] = FT_SINGLE;
    else if (state_q == LOCKED && ftype == FT_HEAD)
      arb_data[DW-1:DW-2] = FT_BODY;
    xfer = arb_valid & can_accept;
  end

`ifdef NOP_LINK_ARB_OUTREG_EN
  logic [DW-1:0] buf_q [2];
  logic          wr_q, rd_q;
  logic [1:0]    cnt_q;
  logic          pop;

  assign can_accept = (cnt_q != 2'd2);
  assign pop        = OUTVALID & OUTREADY;

  always_ff @(posedge CDCLK or negedge CDRESETn) begin
    if (!CDRESETn) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (xfer) begin
        buf_q[wr_q] <= arb_data;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, xfer} - {1'b0, pop};
    end
  end

  always_comb begin
    OUTVALID = (cnt_q != 2'd0);
    OUTDATA  = buf_q[rd_q];
  end
`else
  assign can_accept = OUTREADY;

  always_comb begin
    OUTVALID = arb_valid;
    OUTDATA  = arb_valid ? arb_data : '0;
  end
`endif

  always_ff @(posedge CDCLK or negedge CDRESETn) begin
    if (!CDRESETn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      stall_q     <= 1'b0;
      stall_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      stall_q     <= stall_d;
      stall_idx_q <= stall_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    stall_d     = (state_q == IDLE) & arb_valid & ~can_accept;
    stall_idx_d = sel_idx;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (ftype == FT_HEAD) begin
            state_d = LOCKED;
            owner_d = sel_idx;
          end else begin
            ptr_d = wrap_inc(sel_idx);
          end
        end
      end
      LOCKED: begin
        if (xfer && (ftype == FT_TAIL || ftype == FT_SINGLE)) begin
          state_d = IDLE;
          ptr_d   = wrap_inc(owner_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    GRANT = '0;
    if (sel_en) GRANT[sel_idx] = 1'b1;
    REQREADY = GRANT & {N_REQ{can_accept}};
    BUSY     = (state_q == LOCKED);
  end

endmodule

// File: tb/tb_nop_link_arbiter.sv
// Scoreboard bench for nop_link_arbiter: directed packets, expected flits queued, monitor compares.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_nop_link_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = `DATA_WIDTH;
  localparam logic [1:0] H = 2'b01, B = 2'b00, T = 2'b10, S = 2'b11;

  logic              CDCLK    = 1'b0;
  logic              CDRESETn = 1'b0;
  logic [N*DW-1:0]   REQDATA  = '0;
  logic [N-1:0]      REQVALID = '0;
  logic [N-1:0]      REQREADY;
  logic [DW-1:0]     OUTDATA;
  logic              OUTVALID;
  logic              OUTREADY = 1'b1;
  logic [N-1:0]      GRANT;
  logic              BUSY;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] srcq [N][$];
  logic [DW-1:0] expq [$];

  nop_link_arbiter #(.N_REQ(N)) dut (
    .CDCLK(CDCLK), .CDRESETn(CDRESETn), .REQDATA(REQDATA), .REQVALID(REQVALID),
    .REQREADY(REQREADY), .OUTDATA(OUTDATA), .OUTVALID(OUTVALID), .OUTREADY(OUTREADY),
    .GRANT(GRANT), .BUSY(BUSY)
  );

  initial forever #5 CDCLK = ~CDCLK;

  function automatic logic [DW-1:0] fl(input logic [1:0] ft, input int unsigned id, input int unsigned seq);
    logic [DW-1:0] f;
    f = '0;
    f[DW-1:DW-2] = ft;
    f[15:8] = 8'(id);
    f[7:0]  = 8'(seq);
    return f;
  endfunction

  task automatic sx(input int unsigned i, input logic [1:0] ft, input int unsigned seq);
    srcq[i].push_back(fl(ft, i, seq));
  endtask

  task automatic ex(input int unsigned i, input logic [1:0] ft, input int unsigned seq);
    expq.push_back(fl(ft, i, seq));
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge CDCLK);
      n++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d flits outstanding, required 0", name, expq.size());
      expq.delete();
    end
    repeat (2) @(negedge CDCLK);
  endtask

  // Requester model: holds each queued flit until it is accepted.
  initial begin
    logic [N-1:0] acc;
    forever begin
      @(negedge CDCLK);
      acc = REQVALID & REQREADY;
      @(posedge CDCLK);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        REQVALID[i] = (srcq[i].size() > 0);
        REQDATA[i*DW +: DW] = (srcq[i].size() > 0) ? srcq[i][0] : '0;
      end
    end
  end

  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge CDCLK);
      if (OUTVALID && OUTREADY) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_flit: got %h, required no flit", OUTDATA);
        end else begin
          e = expq.pop_front();
          if (OUTDATA !== e) begin
            errors++;
            $display("FAIL flit_data: got %h, required %h", OUTDATA, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, nx;
    int share [N];
    logic [DW-1:0] stall_exp;

    repeat (2) @(negedge CDCLK);
    chk("rst_grant", GRANT, 0);
    chk("rst_reqready", REQREADY, 0);
    chk("rst_outvalid", OUTVALID, 0);
    chk("rst_outdata", OUTDATA, 0);
    chk("rst_busy", BUSY, 0);
    @(posedge CDCLK); #2 CDRESETn = 1'b1;
    @(negedge CDCLK);

    // Simultaneous singles from 0 and 2, then 1 and 3 with the pointer left at 3.
    sx(0, S, 1); sx(2, S, 1); ex(0, S, 1); ex(2, S, 1);
    @(negedge CDCLK); chk("rr_grant0", GRANT, 4'b0001);
    @(negedge CDCLK); chk("rr_grant1", GRANT, 4'b0100);
    drain("rr");
    sx(1, S, 2); sx(3, S, 2); ex(3, S, 2); ex(1, S, 2);
    @(negedge CDCLK); chk("ptr3_grant", GRANT, 4'b1000);
    drain("ptr3");

    // Pointer now 2; req0 single moves it to 1, then req1 packet beats waiting req0.
    sx(0, S, 3); ex(0, S, 3);
    drain("ptr1");
    sx(1, H, 4); sx(1, B, 5); sx(1, T, 6); sx(0, S, 7);
    ex(1, H, 4); ex(1, B, 5); ex(1, T, 6); ex(0, S, 7);
    @(negedge CDCLK); chk("pkt_grant_h", GRANT, 4'b0010); chk("pkt_busy_h", BUSY, 0);
    @(negedge CDCLK); chk("pkt_grant_b", GRANT, 4'b0010); chk("pkt_busy_b", BUSY, 1);
    @(negedge CDCLK); chk("pkt_grant_t", GRANT, 4'b0010); chk("pkt_busy_t", BUSY, 1);
    @(negedge CDCLK); chk("pkt_next_grant", GRANT, 4'b0001); chk("pkt_next_busy", BUSY, 0);
    drain("pkt");

    // Req2 packet with a second head (forwarded as body) and a 5-cycle downstream stall.
    sx(2, H, 8); sx(2, H, 9); sx(2, B, 10); sx(2, T, 11);
    ex(2, H, 8); ex(2, B, 9); ex(2, B, 10); ex(2, T, 11);
`ifdef NOP_LINK_ARB_OUTREG_EN
    stall_exp = fl(H, 2, 8);
`else
    stall_exp = fl(B, 2, 9);
`endif
    @(negedge CDCLK); chk("stall_head_grant", GRANT, 4'b0100);
    @(posedge CDCLK); #1 OUTREADY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CDCLK);
      chk("stall_grant", GRANT, 4'b0100);
      chk("stall_outvalid", OUTVALID, 1);
      chk("stall_outdata", OUTDATA, stall_exp);
`ifndef NOP_LINK_ARB_OUTREG_EN
      chk("stall_reqready", REQREADY, 0);
`endif
    end
    @(posedge CDCLK); #1 OUTREADY = 1'b1;
    drain("stall");

    // Pointer now 3; reset lands after req3's head, abandoning the rest of the packet.
    sx(3, H, 12); sx(3, B, 13); sx(3, T, 14); ex(3, H, 12);
    @(negedge CDCLK); chk("lock_grant", GRANT, 4'b1000); chk("lock_busy_h", BUSY, 0);
    @(posedge CDCLK); #1 chk("lock_busy", BUSY, 1);
`ifdef NOP_LINK_ARB_OUTREG_EN
    @(posedge CDCLK); #1;
`endif
    #1 CDRESETn = 1'b0;
    srcq[3].delete();
    #1;
    chk("midrst_busy", BUSY, 0);
    chk("midrst_grant", GRANT, 0);
    chk("midrst_reqready", REQREADY, 0);
    chk("midrst_outvalid", OUTVALID, 0);
    @(negedge CDCLK);
    @(posedge CDCLK); #2 CDRESETn = 1'b1;
    @(negedge CDCLK);
    sx(3, S, 15); sx(1, S, 16); ex(1, S, 16); ex(3, S, 15);
    @(negedge CDCLK); chk("postrst_grant", GRANT, 4'b0010);
    drain("postrst");

    // All four stream 100 singles each from pointer 0.
    for (int k = 0; k < 100; k++)
      for (int i = 0; i < N; i++) begin
        sx(i, S, k);
        ex(i, S, k);
      end
    for (int i = 0; i < N; i++) share[i] = 0;
    cyc = 0;
    do begin
      @(negedge CDCLK);
      cyc++;
    end while (!(OUTVALID && OUTREADY) && cyc < 20);
    nx = 0;
    for (int k = 0; k < 400; k++) begin
      if (k > 0) @(negedge CDCLK);
      if (OUTVALID && OUTREADY) begin
        nx++;
        for (int i = 0; i < N; i++)
          if (OUTDATA[15:8] == 8'(i)) share[i]++;
      end
    end
    chk("stream_rate", nx, 400);
    for (int i = 0; i < N; i++) chk("stream_share", share[i], 100);
    drain("stream");

    // Tail with no open packet goes out as a single and must not lock the link.
    sx(0, T, 200); sx(1, S, 201); ex(0, S, 200); ex(1, S, 201);
    @(negedge CDCLK); chk("orphan_grant", GRANT, 4'b0001); chk("orphan_busy", BUSY, 0);
    @(negedge CDCLK); chk("orphan_next_grant", GRANT, 4'b0010); chk("orphan_next_busy", BUSY, 0);
    drain("orphan");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
